// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding, pointer width
// and the round-robin wrap helper.
package fifo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF = 4;
    localparam int PTR_W    = $clog2(NREQ_DEF);

    // Next index after idx in a ring of n requesters.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// Combinational rotating-priority selector: picks the first asserted request at or
// above rr_ptr, wrapping modulo NREQ.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    gnt_valid,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int GID_W = $clog2(NREQ);

    // Scan the ring starting at rr_ptr; the first hit locks out later ones.
    always_comb begin
        int   idx_v;
        logic hit_v;
        idx_v     = 0;
        hit_v     = 1'b0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_v     = (int'(rr_ptr) + i) % NREQ;
            hit_v     = req[idx_v] & ~gnt_valid;
            gnt_idx   = hit_v ? GID_W'(idx_v) : gnt_idx;
            gnt_valid = gnt_valid | hit_v;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter in front of a FIFO memory. Define
// FIFO_ARB_BURST_LOCK_EN to hold the grant until req_last (or MAX_BURST beats).
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    full,
    output logic                    wr_en,
    output logic [WIDTH-1:0]        wr_data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);

    localparam int GID_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state_r;
    logic [GID_W-1:0]  grant_id_r;
    logic [GID_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0]  beat_cnt_r;

    logic              gnt_valid_s;
    logic [GID_W-1:0]  gnt_idx_s;
    logic              hold_valid_s;
    logic [NREQ-1:0]   ready_s;
    logic              xfer_s;
    logic              max_hit_s;
    logic              release_s;
    logic [GID_W-1:0]  next_ptr_s;

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Grant-holder handshake and release decision; non-holders never see ready.
    always_comb begin
        hold_valid_s = req_valid[grant_id_r];
        ready_s      = '0;
        if (state_r == GRANT) begin
            ready_s[grant_id_r] = hold_valid_s & ~full;
        end else begin
            ready_s = '0;
        end
        xfer_s     = hold_valid_s & ready_s[grant_id_r];
        max_hit_s  = (beat_cnt_r == CNT_W'(MAX_BURST - 1));
`ifdef FIFO_ARB_BURST_LOCK_EN
        release_s  = xfer_s & (req_last[grant_id_r] | max_hit_s);
`else
        // A stalled-by-full beat keeps the grant; a dropped valid gives it up.
        release_s  = xfer_s | ~hold_valid_s;
`endif
        next_ptr_s = GID_W'(wrap_inc(int'(grant_id_r), NREQ));
    end

`ifndef FIFO_ARB_BURST_LOCK_EN
    logic unused_s;
    assign unused_s = ^{req_last, max_hit_s};
`endif

    // Arbitration FSM: one IDLE cycle always separates consecutive grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_valid_s) begin
                        state_r    <= GRANT;
                        grant_id_r <= gnt_idx_s;
                        beat_cnt_r <= '0;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r    <= IDLE;
                        rr_ptr_r   <= next_ptr_s;
                    end else if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        state_r    <= GRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign wr_en     = xfer_s;
    assign wr_data   = req_data[int'(grant_id_r) * WIDTH +: WIDTH];
    assign grant_id  = grant_id_r;
    assign busy      = (state_r == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: per-requester beat queues drive the DUT, a
// negedge monitor pops expected {grant_id, data} for every write strobe.
module tb_fifo_wr_arb;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_last  = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic         full = 1'b0;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic [1:0]   grant_id;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [8:0] mem [N][16];
    int         head [N];
    int         tail [N];
    logic [9:0] sb_q [$];
    logic [N-1:0] acc_r = '0;
    logic       prev_wr = 1'b0;
    logic [1:0] prev_id = 2'd0;
    logic [9:0] exp_e;

    always #5 clk = ~clk;

    fifo_wr_arb #(.WIDTH(W), .NREQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record accepted beats before the edge that transfers them.
    always @(negedge clk) acc_r = req_valid & req_ready;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got id %0d data %0h expected none", grant_id, wr_data);
            end else begin
                exp_e = sb_q.pop_front();
                chk("wr_id", {30'd0, grant_id}, {30'd0, exp_e[9:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, exp_e[7:0]});
            end
`ifdef FIFO_ARB_BURST_LOCK_EN
            chk("grant_switch_gap", {31'd0, prev_wr && (grant_id != prev_id)}, 32'd0);
`else
            chk("idle_gap", {31'd0, prev_wr}, 32'd0);
`endif
        end
        prev_wr = wr_en;
        prev_id = grant_id;
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = mem[i][head[i]][7:0];
                req_last[i]        = mem[i][head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic put(input int id, input logic [7:0] d, input logic last);
        mem[id][tail[id]] = {last, d};
        tail[id]++;
    endtask

    task automatic expw(input int id, input logic [7:0] d);
        logic [1:0] id_v;
        id_v = id[1:0];
        sb_q.push_back({id_v, d});
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) p = p | (head[i] < tail[i]);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc_r[i]) head[i]++;
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((pending() || sb_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, (n >= budget)}, 32'd0);
        if (n >= budget) begin
            sb_q.delete();
            clr();
            drive();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        drive();
        // Reset state, including a valid request that must be ignored.
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        put(1, 8'h55, 1'b1);
        drive();
        @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        clr();
        drive();
        rst = 1'b0;

        // Single requester 2, three beats.
        put(2, 8'hA1, 1'b0); put(2, 8'hA2, 1'b0); put(2, 8'hA3, 1'b1);
        expw(2, 8'hA1); expw(2, 8'hA2); expw(2, 8'hA3);
        drive();
        #1;
        chk("arb_latency_busy", {31'd0, busy}, 32'd0);
        chk("arb_latency_ready", {28'd0, req_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("grant2_busy", {31'd0, busy}, 32'd1);
        chk("grant2_id", {30'd0, grant_id}, 32'd2);
        chk("grant2_ready", {28'd0, req_ready}, 32'h4);
        drain("drain_single", 50);
        @(negedge clk);
        chk("single_idle", {31'd0, busy}, 32'd0);

        // rr_ptr is now 3, so requester 3 wins over 0.
        clr();
        put(0, 8'h01, 1'b1); put(3, 8'h03, 1'b1);
        expw(3, 8'h03); expw(0, 8'h01);
        drive();
        drain("drain_ptr", 50);

        // Fairness: all four valid, two beats each, starting at rr_ptr 1.
        clr();
        for (int i = 0; i < N; i++) begin
            put(i, 8'h10 + 8'(i), 1'b0);
            put(i, 8'h20 + 8'(i), 1'b1);
        end
`ifdef FIFO_ARB_BURST_LOCK_EN
        expw(1, 8'h11); expw(1, 8'h21); expw(2, 8'h12); expw(2, 8'h22);
        expw(3, 8'h13); expw(3, 8'h23); expw(0, 8'h10); expw(0, 8'h20);
`else
        expw(1, 8'h11); expw(2, 8'h12); expw(3, 8'h13); expw(0, 8'h10);
        expw(1, 8'h21); expw(2, 8'h22); expw(3, 8'h23); expw(0, 8'h20);
`endif
        drive();
        drain("drain_fair", 100);

        // Backpressure: full for 4 cycles after the first beat.
        clr();
        put(1, 8'hB1, 1'b0); put(1, 8'hB2, 1'b0); put(1, 8'hB3, 1'b1);
        expw(1, 8'hB1); expw(1, 8'hB2); expw(1, 8'hB3);
        drive();
        step();
        step();
        full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_wr_en", {31'd0, wr_en}, 32'd0);
            chk("full_ready", {28'd0, req_ready}, 32'd0);
            if (k >= 1) begin
                chk("full_busy", {31'd0, busy}, 32'd1);
                chk("full_grant", {30'd0, grant_id}, 32'd1);
            end
            step();
        end
        full = 1'b0;
        drain("drain_full", 50);
        @(negedge clk);
        chk("full_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a grant.
        clr();
        put(2, 8'hE0, 1'b0); put(2, 8'hE1, 1'b0); put(2, 8'hE2, 1'b0); put(2, 8'hE3, 1'b1);
        drive();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("arst_grant_id", {30'd0, grant_id}, 32'd0);
        clr();
        drive();
        rst = 1'b0;

        // Long burst from 0 (12 beats) competing with 3 (2 beats).
        for (int b = 0; b < 12; b++) put(0, 8'hC0 + 8'(b), (b == 11));
        put(3, 8'hD0, 1'b0); put(3, 8'hD1, 1'b1);
`ifdef FIFO_ARB_BURST_LOCK_EN
        for (int b = 0; b < 8; b++) expw(0, 8'hC0 + 8'(b));
        expw(3, 8'hD0); expw(3, 8'hD1);
        for (int b = 8; b < 12; b++) expw(0, 8'hC0 + 8'(b));
`else
        expw(0, 8'hC0); expw(3, 8'hD0); expw(0, 8'hC1); expw(3, 8'hD1);
        for (int b = 2; b < 12; b++) expw(0, 8'hC0 + 8'(b));
`endif
        drive();
        step();
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        chk("post_rst_grant", {30'd0, grant_id}, 32'd0);
        drain("drain_burst", 200);
        @(negedge clk);
        chk("burst_idle", {31'd0, busy}, 32'd0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
